// File: rtl/fsm_control_unit_hs.sv
// Multicycle RV32 control FSM: IF -> ID_EX -> [MEM] -> WB with ack-held memory
// requests, bus-timeout trap to a sticky ERR state, resumable HALT and instret.
module fsm_control_unit_hs #(
  parameter int DMEM_WE_W      = 4,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 store,
  input  logic                 branch,
  input  logic                 fence,
  input  logic [DMEM_WE_W-1:0] decoder_dmem_we,
  input  logic                 halt,
  input  logic                 resume,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 pc_we,
  output logic                 imem_rd,
  output logic                 rf_we,
  output logic [DMEM_WE_W-1:0] dmem_we,
  output logic                 dmem_rd,
  output logic                 halted,
  output logic                 bus_err,
  output logic [CNT_W-1:0]     instret,
  output logic [2:0]           dbg_state
);

  // Memory handshake: a request (imem_rd / dmem_rd / dmem_we) is held constant
  // every cycle until the matching ack is sampled high at a rising edge; an ack
  // in the same cycle as the first request cycle completes the transfer.

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID_EX = 3'd1;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  logic [2:0]           r_state;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]     r_instret;

  logic [2:0] w_next;
  logic       w_wait_stay;
  logic       w_timeout;

  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_wait_cnt == TIMEOUT_W'(TO_LAST));

  always_comb begin
    w_next      = r_state;
    w_wait_stay = 1'b0;
    case (r_state)
      S_IF: begin
        // ack in the last allowed cycle wins over the timeout
        if (imem_ack)       w_next = S_ID_EX;
        else if (w_timeout) w_next = S_ERR;
        else                w_wait_stay = 1'b1;
      end
      S_ID_EX: begin
        if (halt)               w_next = S_HALT;
        else if (load || store) w_next = S_MEM;
        else                    w_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)       w_next = S_WB;
        else if (w_timeout) w_next = S_ERR;
        else                w_wait_stay = 1'b1;
      end
      S_WB:    w_next = S_IF;
      S_HALT:  if (resume) w_next = S_WB;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IF;
      r_wait_cnt <= '0;
      r_instret  <= '0;
    end else begin
      r_state <= w_next;
      // any state change clears the counter, so it restarts on IF/MEM entry
      r_wait_cnt <= w_wait_stay ? r_wait_cnt + TIMEOUT_W'(1) : '0;
      if (r_state == S_WB) r_instret <= r_instret + CNT_W'(1);
    end
  end

  always_comb begin
    pc_we   = 1'b0;
    imem_rd = 1'b0;
    rf_we   = 1'b0;
    dmem_we = '0;
    dmem_rd = 1'b0;
    halted  = 1'b0;
    bus_err = 1'b0;
    case (r_state)
      S_IF:  imem_rd = 1'b1;
      S_MEM: begin
        dmem_rd = load;
        dmem_we = store ? decoder_dmem_we : '0;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = !(store || branch || fence || halt);
      end
      S_HALT:  halted  = 1'b1;
      S_ERR:   bus_err = 1'b1;
      default: ;
    endcase
  end

  assign instret   = r_instret;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fsm_control_unit_hs.sv
// Directed bench for fsm_control_unit_hs (TIMEOUT_CYCLES=4, CNT_W=4): expected
// per-cycle output vectors are queued per phase and popped as each cycle runs.
module tb_fsm_control_unit_hs;

  localparam int WE_W = 4;
  localparam int TO   = 4;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic            load, store, branch, fence, halt, resume;
  logic            imem_ack, dmem_ack;
  logic [WE_W-1:0] decoder_dmem_we;
  logic            pc_we, imem_rd, rf_we, dmem_rd, halted, bus_err;
  logic [WE_W-1:0] dmem_we;
  logic [CW-1:0]   instret;
  logic [2:0]      dbg_state;

  logic [13:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  string       tag;

  fsm_control_unit_hs #(
    .DMEM_WE_W(WE_W), .TIMEOUT_W(8), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .load(load), .store(store), .branch(branch),
    .fence(fence), .decoder_dmem_we(decoder_dmem_we), .halt(halt),
    .resume(resume), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .imem_rd(imem_rd), .rf_we(rf_we), .dmem_we(dmem_we),
    .dmem_rd(dmem_rd), .halted(halted), .bus_err(bus_err),
    .instret(instret), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // vector layout: {pc_we, imem_rd, rf_we, dmem_we[3:0], dmem_rd, halted, bus_err, instret[3:0]}
  function automatic logic [13:0] ev(input logic pc, ir, rf, input logic [3:0] we,
                                     input logic dr, hl, be, input logic [3:0] ic);
    return {pc, ir, rf, we, dr, hl, be, ic};
  endfunction

  function automatic logic [13:0] v_if(input int ic);
    return ev(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'(ic));
  endfunction
  function automatic logic [13:0] v_id(input int ic);
    return ev(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'(ic));
  endfunction
  function automatic logic [13:0] v_mem(input logic [3:0] we, input logic dr, input int ic);
    return ev(1'b0, 1'b0, 1'b0, we, dr, 1'b0, 1'b0, 4'(ic));
  endfunction
  function automatic logic [13:0] v_wb(input logic rf, input int ic);
    return ev(1'b1, 1'b0, rf, 4'h0, 1'b0, 1'b0, 1'b0, 4'(ic));
  endfunction
  function automatic logic [13:0] v_halt(input int ic);
    return ev(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'(ic));
  endfunction
  function automatic logic [13:0] v_err(input int ic);
    return ev(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'(ic));
  endfunction

  task automatic set_dec(input logic l, s, b, f, h, input logic [3:0] we);
    load = l; store = s; branch = b; fence = f; halt = h; decoder_dmem_we = we;
  endtask

  // one FSM cycle: drive on the falling edge, compare 1 ns later
  task automatic tick(input logic ia, da, rs, rn);
    logic [13:0] obs;
    logic [13:0] exp_v;
    @(negedge clk);
    imem_ack = ia; dmem_ack = da; resume = rs; rstn = rn;
    #1;
    obs = {pc_we, imem_rd, rf_we, dmem_we, dmem_rd, halted, bus_err, instret};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: no expected entry, observed %h", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic check_drained();
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s: %0d expected cycles left over, required 0", tag, exp_q.size());
    end
  endtask

  initial begin
    rstn = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; resume = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    @(negedge clk);

    tag = "reset";
    exp_q.push_back(v_if(0));
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    assert (dbg_state === 3'd0) else begin
      errors++;
      $error("FAIL reset_state: observed %0d expected 0", dbg_state);
    end
    check_drained();

    // 16 ALU instructions with immediate acks; instret wraps 15 -> 0
    tag = "alu_wrap";
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(v_if(i));
      exp_q.push_back(v_id(i));
      exp_q.push_back(v_wb(1'b1, i));
      repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);
    end
    check_drained();

    tag = "load_waits";
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (3) exp_q.push_back(v_if(0));
    exp_q.push_back(v_id(0));
    repeat (4) exp_q.push_back(v_mem(4'h0, 1'b1, 0));
    exp_q.push_back(v_wb(1'b1, 0));
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_drained();

    tag = "store";
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011);
    exp_q.push_back(v_if(1));
    exp_q.push_back(v_id(1));
    exp_q.push_back(v_mem(4'b0011, 1'b0, 1));
    exp_q.push_back(v_wb(1'b0, 1));
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_drained();

    // halt with load also set: halt must win, no DMem access
    tag = "halt";
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    exp_q.push_back(v_if(2));
    exp_q.push_back(v_id(2));
    repeat (11) exp_q.push_back(v_halt(2));
    exp_q.push_back(v_wb(1'b0, 2));
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_drained();

    tag = "branch_fence";
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    exp_q.push_back(v_if(3));
    exp_q.push_back(v_id(3));
    exp_q.push_back(v_wb(1'b0, 3));
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);
    set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    exp_q.push_back(v_if(4));
    exp_q.push_back(v_id(4));
    exp_q.push_back(v_wb(1'b0, 4));
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b1);
    check_drained();

    // imem ack in the 4th (last allowed) cycle: no error
    tag = "if_ack_last";
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (4) exp_q.push_back(v_if(5));
    exp_q.push_back(v_id(5));
    exp_q.push_back(v_wb(1'b1, 5));
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_drained();

    tag = "reset_mid_mem";
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    exp_q.push_back(v_if(6));
    exp_q.push_back(v_id(6));
    repeat (3) exp_q.push_back(v_mem(4'h0, 1'b1, 6));
    exp_q.push_back(v_if(0));
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_drained();

    // imem never acks: exactly 4 request cycles, then sticky ERR despite acks/resume
    tag = "if_timeout";
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (4) exp_q.push_back(v_if(0));
    repeat (4) exp_q.push_back(v_err(0));
    exp_q.push_back(v_if(0));
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check_drained();

    tag = "mem_timeout";
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    exp_q.push_back(v_if(0));
    exp_q.push_back(v_id(0));
    repeat (4) exp_q.push_back(v_mem(4'h0, 1'b1, 0));
    repeat (3) exp_q.push_back(v_err(0));
    exp_q.push_back(v_if(0));
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check_drained();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_control_unit_hs.md
Name: fsm_control_unit_hs

Overview:
Multicycle RV32 control FSM with memory handshakes. It sequences IF -> ID_EX -> [MEM] -> WB and holds each memory request until the memory acknowledges it, so memories with variable latency are supported. A per-access bus timeout traps to a sticky error state. HALT is resumable, and a retired-instruction counter is provided. It sits between the decoder and the PC, IMem, regfile and DMem enables.

Parameters:
DMEM_WE_W, 4, number of DMem byte-lane write enables.
TIMEOUT_W, 8, width of the wait-cycle counter.
TIMEOUT_CYCLES, 255, maximum cycles a request may be held before a bus error; 0 disables the timeout; must be < 2**TIMEOUT_W.
CNT_W, 32, width of the instret counter.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous active-low reset
load  in  1  decoder: load instruction
store  in  1  decoder: store instruction
branch  in  1  decoder: branch (no RF write)
fence  in  1  decoder: fence (no RF write)
decoder_dmem_we  in  DMEM_WE_W  decoder byte-lane write mask
halt  in  1  decoder: halt instruction
resume  in  1  leave HALT (level, sampled in HALT only)
imem_ack  in  1  IMem completes read this cycle
dmem_ack  in  1  DMem completes read/write this cycle
pc_we  out  1  PC write enable
imem_rd  out  1  IMem read request
rf_we  out  1  regfile write enable
dmem_we  out  DMEM_WE_W  DMem byte write enables
dmem_rd  out  1  DMem read request
halted  out  1  FSM in HALT
bus_err  out  1  FSM in ERR (sticky)
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset is synchronous: when rstn=0 at a clock edge, state <= IF, wait counter <= 0, instret <= 0. Reset overrides everything, including reset mid-wait, in HALT, or in ERR.
- All outputs are combinational from state and inputs. Default value of every output is 0.
- In the cycle after reset, the FSM is in IF with imem_rd=1. All other outputs are 0 and instret=0.
- IF:
  - imem_rd=1.
  - If imem_ack=1 -> ID_EX. An ack in the same cycle as the request is legal, giving 1 cycle in IF.
  - Otherwise stay in IF and increment the wait counter.
- ID_EX: no outputs asserted.
  - halt -> HALT.
  - Else load|store -> MEM.
  - Else -> WB.
  - halt has priority over load/store.
- MEM:
  - dmem_rd=load.
  - dmem_we=decoder_dmem_we if store, else 0.
  - Both are held constant until dmem_ack=1, then -> WB.
  - load and store both high is illegal; the output is undefined but the FSM must still exit on ack.
- WB: 1 cycle, then -> IF.
  - pc_we=1.
  - rf_we = !(store|branch|fence|halt).
  - instret increments by 1, wrapping modulo 2**CNT_W.
- HALT:
  - halted=1, no other outputs.
  - resume=1 -> WB, so the PC advances past the halt and rf_we=0.
  - Otherwise stay in HALT.
- ERR:
  - bus_err=1, all other outputs 0.
  - No exit except reset.
- Timeout:
  - The wait counter clears on every entry to IF or MEM.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES-1 with no ack, the next state is ERR. A request is therefore held at most TIMEOUT_CYCLES cycles.
  - An ack in the final allowed cycle wins over the timeout.
- Illegal or unused state encodings -> IF.
- Decoder inputs are assumed stable from ID_EX through WB.
- Latency with immediate acks:
  - ALU/branch instruction: 3 cycles (IF, ID_EX, WB).
  - Load/store: 4 cycles.
  - Each cycle of ack delay adds one cycle.

Test Plan:
- ALU instruction, imem_ack tied 1 -> imem_rd cycle 1, nothing cycle 2, pc_we=1 and rf_we=1 cycle 3; instret 0 -> 1; repeats with a period of 3.
- Load, imem_ack after 2 wait cycles, dmem_ack after 3 -> imem_rd high 3 cycles, dmem_rd high 4 cycles, then WB with rf_we=1; total 9 cycles.
- Store with decoder_dmem_we=4'b0011, dmem_ack immediate -> dmem_we=4'b0011 for exactly 1 cycle, dmem_rd=0, WB with rf_we=0 and pc_we=1.
- TIMEOUT_CYCLES=4, imem_ack held 0 -> imem_rd high exactly 4 cycles, then bus_err=1 permanently. Ack on the 4th cycle instead -> ID_EX, no error.
- halt instruction -> halted=1 held for 10 cycles with resume=0. resume=1 -> WB with pc_we=1, rf_we=0, instret+1, then IF.
- CNT_W=4, 16 ALU instructions -> instret wraps 15 -> 0. Assert rstn=0 during a MEM wait -> next cycle in IF, dmem_rd=0, instret=0.
